// File: rtl/ram_sp_be_192x512_wrctl.sv
// Write-combining front end for the 192x512 bit-enable line RAM: packs 128-bit beats
// into a one-line merge buffer, arbitrates the single RAM port and returns read data.
module ram_sp_be_192x512_wrctl #(
  parameter int ADR_WD  = 8,
  parameter int DEPTH   = 192,
  parameter int DAT_WD  = 512,
  parameter int BEAT_WD = 128
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_val_i,
  output logic                             wr_rdy_o,
  input  logic [ADR_WD-1:0]                wr_adr_i,
  input  logic [$clog2(DAT_WD/BEAT_WD)-1:0] wr_sel_i,
  input  logic [BEAT_WD-1:0]               wr_dat_i,
  input  logic                             rd_val_i,
  output logic                             rd_rdy_o,
  input  logic [ADR_WD-1:0]                rd_adr_i,
  output logic                             rd_dat_val_o,
  output logic [DAT_WD-1:0]                rd_dat_o,
  input  logic                             flush_i,
  output logic                             idle_o,
  output logic                             adr_err_o,
  output logic [ADR_WD-1:0]                ram_adr_o,
  output logic [DAT_WD-1:0]                ram_wr_ena_o,
  output logic [DAT_WD-1:0]                ram_wr_dat_o,
  output logic                             ram_rd_ena_o,
  input  logic [DAT_WD-1:0]                ram_rd_dat_i
);

  localparam int NUM_BEAT = DAT_WD / BEAT_WD;
  localparam int SEL_WD   = $clog2(NUM_BEAT);
  localparam logic [ADR_WD:0] DEPTH_W = (ADR_WD+1)'(DEPTH);

  logic                buf_vld_q, buf_vld_d;
  logic [ADR_WD-1:0]   buf_adr_q, buf_adr_d;
  logic [NUM_BEAT-1:0] buf_msk_q, buf_msk_d;
  logic [DAT_WD-1:0]   buf_dat_q, buf_dat_d;
  logic                rd_dat_val_q;
  logic                adr_err_q, adr_err_d;

  logic flush;
  logic wr_acc, rd_acc;
  logic wr_legal, rd_legal;
  logic [NUM_BEAT-1:0] sel_onehot;

  assign wr_legal   = {1'b0, wr_adr_i} < DEPTH_W;
  assign rd_legal   = {1'b0, rd_adr_i} < DEPTH_W;
  assign sel_onehot = NUM_BEAT'(1) << wr_sel_i;

  // The buffer goes out when full, displaced by another line, needed by a reader, or forced.
  assign flush = buf_vld_q & ((&buf_msk_q)
                              | (wr_val_i & (wr_adr_i != buf_adr_q))
                              | (rd_val_i & (rd_adr_i == buf_adr_q))
                              | flush_i);

  // A pending read holds off new beats during a flush so it wins the port next cycle.
  assign wr_rdy_o = !rst & (flush ? !rd_val_i : 1'b1);
  assign rd_rdy_o = !rst & !flush;
  assign wr_acc   = wr_val_i & wr_rdy_o;
  assign rd_acc   = rd_val_i & rd_rdy_o;

  assign ram_rd_ena_o = rd_acc & rd_legal;
  assign ram_adr_o    = flush ? buf_adr_q : rd_adr_i;
  assign ram_wr_dat_o = buf_dat_q;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    ram_wr_ena_o = '0;
    for (int q = 0; q < NUM_BEAT; q++) begin
      ram_wr_ena_o[q*BEAT_WD +: BEAT_WD] = {BEAT_WD{flush & buf_msk_q[q]}};
    end
  end

  always_comb begin
    buf_vld_d = buf_vld_q;
    buf_adr_d = buf_adr_q;
    buf_msk_d = buf_msk_q;
    buf_dat_d = buf_dat_q;
    adr_err_d = adr_err_q | (wr_acc & !wr_legal) | (rd_acc & !rd_legal);
    if (flush) begin
      buf_vld_d = 1'b0;
      buf_msk_d = '0;
    end
    if (wr_acc && wr_legal) begin
      // Without a flush, a valid buffer here is guaranteed to hold wr_adr_i already.
      if (flush || !buf_vld_q) begin
        buf_vld_d = 1'b1;
        buf_adr_d = wr_adr_i;
        buf_msk_d = sel_onehot;
      end else begin
        buf_msk_d = buf_msk_q | sel_onehot;
      end
      for (int q = 0; q < NUM_BEAT; q++) begin
        if (wr_sel_i == SEL_WD'(q)) buf_dat_d[q*BEAT_WD +: BEAT_WD] = wr_dat_i;
      end
    end
  end

  // NOTE: sequential state is assigned with <= so all registers sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_vld_q    <= 1'b0;
      buf_adr_q    <= '0;
      buf_msk_q    <= '0;
      rd_dat_val_q <= 1'b0;
      adr_err_q    <= 1'b0;
    end else begin
      buf_vld_q    <= buf_vld_d;
      buf_adr_q    <= buf_adr_d;
      buf_msk_q    <= buf_msk_d;
      rd_dat_val_q <= ram_rd_ena_o;
      adr_err_q    <= adr_err_d;
    end
  end

  // NOTE: the line data needs no reset; buf_msk_q qualifies every quarter before it is used.
  always_ff @(posedge clk) begin
    buf_dat_q <= buf_dat_d;
  end

  assign rd_dat_val_o = rd_dat_val_q;
  assign rd_dat_o     = ram_rd_dat_i;
  assign idle_o       = !buf_vld_q;
  assign adr_err_o    = adr_err_q;

endmodule

// File: tb/tb_ram_sp_be_192x512_wrctl.sv
// Bench for ram_sp_be_192x512_wrctl: behavioural RAM plus a "latest written beat" memory
// image that every returned read and the final RAM contents are compared against.
module tb_ram_sp_be_192x512_wrctl;

  localparam int ADR_WD  = 8;
  localparam int DEPTH   = 192;
  localparam int DAT_WD  = 512;
  localparam int BEAT_WD = 128;
  localparam int NB      = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               wr_val_i, wr_rdy_o;
  logic [ADR_WD-1:0]  wr_adr_i;
  logic [1:0]         wr_sel_i;
  logic [BEAT_WD-1:0] wr_dat_i;
  logic               rd_val_i, rd_rdy_o;
  logic [ADR_WD-1:0]  rd_adr_i;
  logic               rd_dat_val_o;
  logic [DAT_WD-1:0]  rd_dat_o;
  logic               flush_i, idle_o, adr_err_o;
  logic [ADR_WD-1:0]  ram_adr_o;
  logic [DAT_WD-1:0]  ram_wr_ena_o, ram_wr_dat_o;
  logic               ram_rd_ena_o;
  logic [DAT_WD-1:0]  ram_rd_dat_i;

  always #5 clk = ~clk;

  ram_sp_be_192x512_wrctl dut (
    .clk(clk), .rst(rst),
    .wr_val_i(wr_val_i), .wr_rdy_o(wr_rdy_o), .wr_adr_i(wr_adr_i),
    .wr_sel_i(wr_sel_i), .wr_dat_i(wr_dat_i),
    .rd_val_i(rd_val_i), .rd_rdy_o(rd_rdy_o), .rd_adr_i(rd_adr_i),
    .rd_dat_val_o(rd_dat_val_o), .rd_dat_o(rd_dat_o),
    .flush_i(flush_i), .idle_o(idle_o), .adr_err_o(adr_err_o),
    .ram_adr_o(ram_adr_o), .ram_wr_ena_o(ram_wr_ena_o), .ram_wr_dat_o(ram_wr_dat_o),
    .ram_rd_ena_o(ram_rd_ena_o), .ram_rd_dat_i(ram_rd_dat_i)
  );

  // Behavioural bit-enable RAM with one cycle read latency.
  logic              mem_init;
  logic [DAT_WD-1:0] seed   [256];
  logic [DAT_WD-1:0] mem    [256];
  logic [DAT_WD-1:0] golden [256];
  logic [DAT_WD-1:0] snap   [256];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int a = 0; a < 256; a++) mem[a] <= seed[a];
    end else begin
      if (ram_rd_ena_o) ram_rd_dat_i <= mem[ram_adr_o];
      if (|ram_wr_ena_o)
        mem[ram_adr_o] <= (mem[ram_adr_o] & ~ram_wr_ena_o) | (ram_wr_dat_o & ram_wr_ena_o);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state at transaction level.
  bit                pend;
  logic [DAT_WD-1:0] pend_dat;
  bit                exp_err;
  int                stall;
  bit                last_wacc, last_racc;

  function automatic logic [DAT_WD-1:0] qmask(input int q);
    logic [DAT_WD-1:0] m;
    m = '0;
    m[q*BEAT_WD +: BEAT_WD] = '1;
    return m;
  endfunction

  task automatic monitor();
    bit wacc, racc, wleg, rleg, q_ok;
    if (rst) return;
    wacc = wr_val_i && wr_rdy_o;
    racc = rd_val_i && rd_rdy_o;
    wleg = int'(wr_adr_i) < DEPTH;
    rleg = int'(rd_adr_i) < DEPTH;
    n_tests++;
    if (pend) begin
      if (rd_dat_val_o !== 1'b1 || rd_dat_o !== pend_dat) begin
        n_fail++;
        $display("FAIL rd_data val=%b got %h exp %h", rd_dat_val_o, rd_dat_o, pend_dat);
      end
    end else if (rd_dat_val_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_dat_val_spurious got %b exp 0", rd_dat_val_o);
    end
    n_tests++;
    if (adr_err_o !== exp_err) begin
      n_fail++;
      $display("FAIL adr_err got %b exp %b", adr_err_o, exp_err);
    end
    n_tests++;
    if (ram_rd_ena_o !== (racc && rleg) || (ram_rd_ena_o && ram_adr_o !== rd_adr_i)) begin
      n_fail++;
      $display("FAIL rd_issue ena=%b adr=%0d exp ena=%b adr=%0d", ram_rd_ena_o, ram_adr_o,
               racc && rleg, rd_adr_i);
    end
    q_ok = 1'b1;
    for (int q = 0; q < NB; q++) begin
      if ((ram_wr_ena_o & qmask(q)) != '0 && (ram_wr_ena_o & qmask(q)) != qmask(q)) q_ok = 1'b0;
    end
    n_tests++;
    if (!q_ok || (|ram_wr_ena_o && (ram_rd_ena_o || int'(ram_adr_o) >= DEPTH))) begin
      n_fail++;
      $display("FAIL wr_port ena=%h rd=%b adr=%0d exp whole quarters, no rd, adr<%0d",
               ram_wr_ena_o, ram_rd_ena_o, ram_adr_o, DEPTH);
    end
    if (!wr_rdy_o) begin
      n_tests++;
      if (!(rd_val_i && |ram_wr_ena_o)) begin
        n_fail++;
        $display("FAIL wr_rdy_low got rd_val=%b wr_busy=%b exp both 1", rd_val_i, |ram_wr_ena_o);
      end
    end
    if (rd_val_i && !rd_rdy_o) begin
      stall++;
      n_tests++;
      if (stall > 1 || ram_wr_ena_o == '0) begin
        n_fail++;
        $display("FAIL rd_stall got %0d cycles wr_busy=%b exp <=1 with write", stall, |ram_wr_ena_o);
      end
    end else begin
      stall = 0;
    end
    pend = racc && rleg;
    if (pend) pend_dat = golden[rd_adr_i];
    if (racc && !rleg) exp_err = 1'b1;
    if (wacc) begin
      if (wleg) golden[wr_adr_i][int'(wr_sel_i)*BEAT_WD +: BEAT_WD] = wr_dat_i;
      else exp_err = 1'b1;
    end
    last_wacc = wacc;
    last_racc = racc;
  endtask

  task automatic sample();
    @(negedge clk);
    monitor();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    wr_val_i = 1'b0; wr_adr_i = '0; wr_sel_i = '0; wr_dat_i = '0;
    rd_val_i = 1'b0; rd_adr_i = '0; flush_i = 1'b0;
  endtask

  task automatic beat(input int adr, input int sel, input logic [BEAT_WD-1:0] dat);
    wr_val_i = 1'b1; wr_adr_i = ADR_WD'(adr); wr_sel_i = 2'(sel); wr_dat_i = dat;
  endtask

  task automatic flush_buffer();
    set_idle();
    flush_i = 1'b1;
    sample(); advance();
    flush_i = 1'b0;
    sample(); advance();
  endtask

  task automatic test_reset();
    wr_val_i = 1'b1; rd_val_i = 1'b1; rd_adr_i = 8'd4; flush_i = 1'b1;
    @(negedge clk);
    n_tests++;
    if (wr_rdy_o !== 1'b0 || rd_rdy_o !== 1'b0 || ram_rd_ena_o !== 1'b0 || ram_wr_ena_o !== '0) begin
      n_fail++;
      $display("FAIL reset_port got wr_rdy=%b rd_rdy=%b rd_ena=%b wr_ena=%h exp all 0",
               wr_rdy_o, rd_rdy_o, ram_rd_ena_o, ram_wr_ena_o);
    end
    n_tests++;
    if (idle_o !== 1'b1 || adr_err_o !== 1'b0 || rd_dat_val_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got idle=%b err=%b rd_val=%b exp 1 0 0", idle_o, adr_err_o, rd_dat_val_o);
    end
    set_idle();
    advance();
    rst = 1'b0;
  endtask

  task automatic test_full_line();
    logic [DAT_WD-1:0] exp_line;
    for (int q = 0; q < NB; q++) begin
      beat(5, q, {16{8'(8'h11 * (q + 1))}});
      exp_line[q*BEAT_WD +: BEAT_WD] = {16{8'(8'h11 * (q + 1))}};
      sample();
      n_tests++;
      if (wr_rdy_o !== 1'b1 || ram_wr_ena_o !== '0) begin
        n_fail++;
        $display("FAIL full_merge q=%0d got rdy=%b wr_ena=%h exp 1 0", q, wr_rdy_o, ram_wr_ena_o);
      end
      advance();
    end
    set_idle();
    sample();
    n_tests++;
    if (ram_adr_o !== 8'd5 || ram_wr_ena_o !== '1 || ram_wr_dat_o !== exp_line) begin
      n_fail++;
      $display("FAIL full_write got adr=%0d ena=%h dat=%h exp 5 all-ones %h",
               ram_adr_o, ram_wr_ena_o, ram_wr_dat_o, exp_line);
    end
    advance();
    sample();
    n_tests++;
    if (idle_o !== 1'b1 || ram_wr_ena_o !== '0) begin
      n_fail++;
      $display("FAIL full_idle got idle=%b ena=%h exp 1 0", idle_o, ram_wr_ena_o);
    end
    advance();
  endtask

  task automatic test_addr_switch();
    logic [BEAT_WD-1:0] d1, d2;
    d1 = {4{$urandom}};
    d2 = {4{$urandom}};
    beat(7, 1, d1);
    sample(); advance();
    beat(9, 0, d2);
    sample();
    n_tests++;
    if (ram_adr_o !== 8'd7 || ram_wr_ena_o !== qmask(1) || ram_wr_dat_o[255:128] !== d1 || wr_rdy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL switch_write got adr=%0d ena=%h dat=%h rdy=%b exp 7 q1 %h 1",
               ram_adr_o, ram_wr_ena_o, ram_wr_dat_o[255:128], wr_rdy_o, d1);
    end
    advance();
    set_idle();
    sample();
    n_tests++;
    if (ram_wr_ena_o !== '0 || idle_o !== 1'b0) begin
      n_fail++;
      $display("FAIL switch_hold got ena=%h idle=%b exp 0 0", ram_wr_ena_o, idle_o);
    end
    advance();
    flush_i = 1'b1;
    sample();
    n_tests++;
    if (ram_adr_o !== 8'd9 || ram_wr_ena_o !== qmask(0) || ram_wr_dat_o[127:0] !== d2) begin
      n_fail++;
      $display("FAIL switch_flush got adr=%0d ena=%h dat=%h exp 9 q0 %h",
               ram_adr_o, ram_wr_ena_o, ram_wr_dat_o[127:0], d2);
    end
    advance();
    flush_i = 1'b0;
    sample();
    n_tests++;
    if (idle_o !== 1'b1) begin
      n_fail++;
      $display("FAIL switch_idle got %b exp 1", idle_o);
    end
    advance();
    sample();
    n_tests++;
    if (ram_wr_ena_o !== '0) begin
      n_fail++;
      $display("FAIL flush_empty got ena=%h exp 0", ram_wr_ena_o);
    end
    advance();
  endtask

  task automatic test_raw();
    logic [BEAT_WD-1:0] d;
    d = {4{$urandom}};
    beat(3, 2, d);
    sample(); advance();
    beat(4, 0, {4{$urandom}});
    rd_val_i = 1'b1; rd_adr_i = 8'd3;
    sample();
    n_tests++;
    if (rd_rdy_o !== 1'b0 || wr_rdy_o !== 1'b0 || ram_adr_o !== 8'd3 || ram_wr_ena_o !== qmask(2)) begin
      n_fail++;
      $display("FAIL raw_flush got rd_rdy=%b wr_rdy=%b adr=%0d ena=%h exp 0 0 3 q2",
               rd_rdy_o, wr_rdy_o, ram_adr_o, ram_wr_ena_o);
    end
    advance();
    sample();
    n_tests++;
    if (rd_rdy_o !== 1'b1 || ram_rd_ena_o !== 1'b1 || ram_adr_o !== 8'd3 || wr_rdy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_read got rd_rdy=%b rd_ena=%b adr=%0d wr_rdy=%b exp 1 1 3 1",
               rd_rdy_o, ram_rd_ena_o, ram_adr_o, wr_rdy_o);
    end
    advance();
    set_idle();
    sample();
    n_tests++;
    if (rd_dat_val_o !== 1'b1 || rd_dat_o[383:256] !== d) begin
      n_fail++;
      $display("FAIL raw_data got val=%b q2=%h exp 1 %h", rd_dat_val_o, rd_dat_o[383:256], d);
    end
    advance();
    flush_buffer();
  endtask

  task automatic test_read_bypass();
    beat(3, 0, {4{$urandom}});
    sample(); advance();
    set_idle();
    rd_val_i = 1'b1; rd_adr_i = 8'd10;
    sample();
    n_tests++;
    if (rd_rdy_o !== 1'b1 || ram_rd_ena_o !== 1'b1 || ram_adr_o !== 8'd10 || ram_wr_ena_o !== '0) begin
      n_fail++;
      $display("FAIL bypass_issue got rdy=%b rd_ena=%b adr=%0d wr_ena=%h exp 1 1 10 0",
               rd_rdy_o, ram_rd_ena_o, ram_adr_o, ram_wr_ena_o);
    end
    advance();
    set_idle();
    sample();
    n_tests++;
    if (rd_dat_val_o !== 1'b1 || idle_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_data got val=%b idle=%b exp 1 0", rd_dat_val_o, idle_o);
    end
    advance();
    flush_buffer();
  endtask

  task automatic test_addr_err();
    beat(200, 1, {4{$urandom}});
    rd_val_i = 1'b1; rd_adr_i = 8'd192;
    sample();
    n_tests++;
    if (wr_rdy_o !== 1'b1 || rd_rdy_o !== 1'b1 || ram_rd_ena_o !== 1'b0 || ram_wr_ena_o !== '0) begin
      n_fail++;
      $display("FAIL err_accept got wr_rdy=%b rd_rdy=%b rd_ena=%b wr_ena=%h exp 1 1 0 0",
               wr_rdy_o, rd_rdy_o, ram_rd_ena_o, ram_wr_ena_o);
    end
    advance();
    set_idle();
    for (int i = 0; i < 3; i++) begin
      sample();
      n_tests++;
      if (adr_err_o !== 1'b1 || rd_dat_val_o !== 1'b0 || idle_o !== 1'b1 || ram_wr_ena_o !== '0) begin
        n_fail++;
        $display("FAIL err_sticky cyc=%0d got err=%b rd_val=%b idle=%b exp 1 0 1",
                 i, adr_err_o, rd_dat_val_o, idle_o);
      end
      advance();
    end
  endtask

  function automatic int pick_adr();
    int r;
    r = $urandom_range(0, 99);
    if (r < 4) return $urandom_range(DEPTH, 255);
    if (r < 10) return (r < 7) ? 0 : DEPTH - 1;
    case ($urandom_range(0, 3))
      0: return 5;
      1: return 6;
      2: return 100;
      default: return DEPTH - 1;
    endcase
  endfunction

  task automatic test_random();
    set_idle();
    last_wacc = 1'b0;
    last_racc = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!wr_val_i || last_wacc) begin
        wr_val_i = $urandom_range(0, 99) < 60;
        wr_adr_i = ADR_WD'(pick_adr());
        wr_sel_i = 2'($urandom_range(0, 3));
        wr_dat_i = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!rd_val_i || last_racc) begin
        rd_val_i = $urandom_range(0, 99) < 30;
        rd_adr_i = ADR_WD'(pick_adr());
      end
      flush_i = $urandom_range(0, 99) < 5;
      sample(); advance();
    end
    flush_buffer();
    sample();
    n_tests++;
    if (idle_o !== 1'b1) begin
      n_fail++;
      $display("FAIL random_idle got %b exp 1", idle_o);
    end
    advance();
  endtask

  task automatic test_reset_mid();
    for (int a = 0; a < 256; a++) snap[a] = golden[a];
    beat(20, 0, {4{$urandom}});
    sample(); advance();
    beat(20, 1, {4{$urandom}});
    sample(); advance();
    rst = 1'b1;
    set_idle();
    rd_val_i = 1'b1; rd_adr_i = 8'd20; flush_i = 1'b1;
    @(negedge clk);
    n_tests++;
    if (idle_o !== 1'b1 || ram_wr_ena_o !== '0 || ram_rd_ena_o !== 1'b0 || wr_rdy_o !== 1'b0 || rd_rdy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset got idle=%b wr_ena=%h rd_ena=%b wr_rdy=%b rd_rdy=%b exp 1 0 0 0 0",
               idle_o, ram_wr_ena_o, ram_rd_ena_o, wr_rdy_o, rd_rdy_o);
    end
    for (int a = 0; a < 256; a++) golden[a] = snap[a];
    exp_err = 1'b0; pend = 1'b0; stall = 0;
    advance();
    set_idle();
    rst = 1'b0;
    flush_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      n_tests++;
      if (ram_wr_ena_o !== '0 || idle_o !== 1'b1) begin
        n_fail++;
        $display("FAIL midreset_nowrite cyc=%0d got ena=%h idle=%b exp 0 1", i, ram_wr_ena_o, idle_o);
      end
      advance();
    end
    set_idle();
  endtask

  task automatic test_ram_image();
    int errs, first;
    errs = 0;
    first = -1;
    for (int a = 0; a < DEPTH; a++) begin
      if (mem[a] !== golden[a]) begin
        errs++;
        if (first < 0) first = a;
      end
    end
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL ram_image got %0d bad lines (first adr %0d: %h) exp 0 (%h)",
               errs, first, mem[first], golden[first]);
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_init = 1'b1;
    set_idle();
    pend = 1'b0; exp_err = 1'b0; stall = 0;
    for (int a = 0; a < 256; a++) begin
      for (int w = 0; w < DAT_WD / 32; w++) seed[a][w*32 +: 32] = $urandom;
      golden[a] = seed[a];
    end
    repeat (2) @(posedge clk);
    #1;
    mem_init = 1'b0;
    test_reset();
    test_full_line();
    test_addr_switch();
    test_raw();
    test_read_bypass();
    test_addr_err();
    test_random();
    test_reset_mid();
    test_ram_image();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
